// File: rtl/frame_fifo.sv
// frame_fifo: circular frame buffer between serial_handler and n64_controller.
// Define FRAME_FIFO_REPEAT_ON_UNDERFLOW_EN to repeat the last frame on underflow.
module frame_fifo #(
  parameter int DEPTH     = 16,
  parameter int LOW_WATER = 4
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [31:0]            wr_data,
  input  logic                   frame_pop,
  output logic [31:0]            frame_data,
  output logic                   frame_valid,
  output logic                   request_frame,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LOW  = LW'(LOW_WATER);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic empty;
  logic full;
  logic do_pop;
  logic do_wr;
  logic under;
  logic drop;

  // A pop on a full FIFO frees the slot the same-cycle write lands in;
  // a pop on an empty FIFO never sees the same-cycle write.
  always_comb begin
    empty  = (level == '0);
    full   = (level == FULL);
    do_pop = frame_pop & ~empty & ~flush;
    under  = frame_pop &  empty & ~flush;
    do_wr  = wr_en & ~flush & (~full | do_pop);
    drop   = wr_en & ~flush & full & ~frame_pop;
  end

  // Frame storage; contents are never cleared, only the pointers are.
  always_ff @(posedge sys_clk) begin
    if (!reset && do_wr)
      mem[wr_ptr] <= wr_data;
  end

  // Pointers and occupancy; flush clears them like reset does.
  always_ff @(posedge sys_clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (do_wr & ~do_pop): level <= level + LW'(1);
        (do_pop & ~do_wr): level <= level - LW'(1);
        default:           level <= level;
      endcase
    end
  end

  // Presented frame: head entry one cycle after a pop.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
    end else if (do_pop) begin
      frame_data  <= mem[rd_ptr];
      frame_valid <= 1'b1;
    end else if (under) begin
`ifdef FRAME_FIFO_REPEAT_ON_UNDERFLOW_EN
      frame_data  <= frame_data;
`else
      frame_data  <= '0;
`endif
    end
  end

  // Sticky error flags; flush leaves them alone.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop)
        overflow <= 1'b1;
      if (under)
        underflow <= 1'b1;
    end
  end

  // Refill request trails the occupancy by one cycle.
  always_ff @(posedge sys_clk) begin
    if (reset)
      request_frame <= 1'b1;
    else
      request_frame <= (level < LOW);
  end

endmodule
